// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer frame sequencer.
//   state_e   : sequencer phases (LOAD, SETTLE, DRAIN)
//   *_DEF     : default layer geometry
//   cnt_w     : counter width for a count of n items (at least 1 bit)
//   idx_w     : index width for n items (at least 1 bit)
//   slice_lo  : low bit of element idx in a flattened vector of w-bit elements
package fc_seq_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int WIDTH_DEF   = 8;
    localparam int IN_DEF      = 400;
    localparam int NEURONS_DEF = 10;
    localparam int ZW_DEF      = 2 * WIDTH_DEF + $clog2(IN_DEF);

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(IN_DEF);
    localparam int IDX_W = idx_w(NEURONS_DEF);

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Streaming handshake bundle of the layer sequencer.
//   in_valid/in_ready/in_data          : one activation per beat into the sequencer
//   out_valid/out_ready/out_data/
//   out_idx/out_last                   : one neuron result per beat out of it
// slave is the sequencer side, master is the producer/consumer side.
interface fc_layer_seq_if
    import fc_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ZW    = ZW_DEF,
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ZW-1:0]    out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/fc_frame_buf.sv
// Frame buffer: IN x WIDTH register file written one element at a time and
// read all at once as a flattened vector (element k at [k*WIDTH +: WIDTH]).
//   clk, rst : clock, synchronous active-high reset (clears the buffer)
//   we       : write strobe
//   waddr    : element index to write
//   wdata    : element value
//   x_out    : whole buffer, flattened
module fc_frame_buf
    import fc_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IN    = IN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [cnt_w(IN)-1:0]  waddr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [IN*WIDTH-1:0]   x_out
);
    logic [IN-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign x_out = mem;
endmodule

// File: rtl/fc_layer_seq.sv
// Frame sequencer around the combinational fully-connected layer.
// Collects IN activations into the frame buffer, holds the buffer on x_out
// for LAT cycles so the layer can settle, snapshots every neuron result from
// z_in, then streams the NEURONS results out one per handshake.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : abort current frame (counters/state only, data kept)
//   bus        : activation input and result output handshakes
//   x_out      : frame buffer driven to every layer instance
//   z_in       : flattened layer results, neuron n at [n*ZW +: ZW]
//   busy       : high in SETTLE and DRAIN
//   frame_done : one-cycle pulse after the last result is accepted
// x_out -> cap is a LAT-cycle multicycle path: z_in is sampled exactly LAT
// cycles after the last activation is written, and x_out is frozen meanwhile.
module fc_layer_seq
    import fc_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int IN      = IN_DEF,
    parameter int NEURONS = NEURONS_DEF,
    parameter int ZW      = 2 * WIDTH + $clog2(IN),
    parameter int LAT     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fc_layer_seq_if.slave          bus,
    output logic [IN*WIDTH-1:0]    x_out,
    input  logic [NEURONS*ZW-1:0]  z_in,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int CW = cnt_w(IN);
    localparam int IW = idx_w(NEURONS);

    localparam logic [1:0] ST_LOAD   = 2'(LOAD);
    localparam logic [1:0] ST_SETTLE = 2'(SETTLE);
    localparam logic [1:0] ST_DRAIN  = 2'(DRAIN);

    logic [1:0]                 state;
    logic [CW-1:0]              wr_cnt;
    logic [IW-1:0]              rd_cnt;
    logic [7:0]                 set_cnt;
    logic [NEURONS-1:0][ZW-1:0] cap;
    logic                       in_acc;
    logic                       out_acc;
    logic                       last_rd;

    // flush discards a coincident beat on either side
    assign in_acc  = (state == ST_LOAD)  && bus.in_valid  && !flush;
    assign out_acc = (state == ST_DRAIN) && bus.out_ready && !flush;
    assign last_rd = (rd_cnt == IW'(NEURONS - 1));

    assign bus.in_ready  = (state == ST_LOAD);
    assign bus.out_valid = (state == ST_DRAIN);
    assign bus.out_idx   = rd_cnt;
    assign bus.out_last  = (state == ST_DRAIN) && last_rd;
    // zero outside DRAIN so an idle port looks like the reset state
    assign bus.out_data  = (state == ST_DRAIN) ? cap[rd_cnt] : '0;
    assign busy          = (state != ST_LOAD);

    fc_frame_buf #(
        .WIDTH (WIDTH),
        .IN    (IN)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (in_acc),
        .waddr (wr_cnt),
        .wdata (bus.in_data),
        .x_out (x_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            set_cnt    <= '0;
            cap        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (flush) begin
                state   <= ST_LOAD;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                set_cnt <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (in_acc) begin
                            if (wr_cnt == CW'(IN - 1)) begin
                                wr_cnt  <= '0;
                                set_cnt <= '0;
                                state   <= ST_SETTLE;
                            end else begin
                                wr_cnt <= wr_cnt + 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (set_cnt == 8'(LAT - 1)) begin
                            cap     <= z_in;
                            rd_cnt  <= '0;
                            set_cnt <= '0;
                            state   <= ST_DRAIN;
                        end else begin
                            set_cnt <= set_cnt + 8'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (out_acc) begin
                            if (last_rd) begin
                                rd_cnt     <= '0;
                                frame_done <= 1'b1;
                                state      <= ST_LOAD;
                            end else begin
                                rd_cnt <= rd_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_LOAD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq with IN=4, NEURONS=3, WIDTH=8.
// dut (LAT=2) is fed by a behavioural dot-product layer; dut1 (LAT=1) gets a
// bench-driven z_in so the capture cycle can be pinned down.
// Layer weights: neuron0 = 1,1,1,1; neuron1 = 1,2,3,4; neuron2 = 4,3,2,1.
module tb_fc_layer_seq;
    import fc_seq_pkg::*;

    localparam int WIDTH   = 8;
    localparam int IN      = 4;
    localparam int NEURONS = 3;
    localparam int ZW      = 2 * WIDTH + $clog2(IN);
    localparam int IW      = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, flush, flush1;
    logic [IN*WIDTH-1:0]   x_out, x_out1;
    logic [NEURONS*ZW-1:0] z_in, z_in1;
    logic                  busy, frame_done, busy1, frame_done1;

    fc_layer_seq_if #(.WIDTH(WIDTH), .ZW(ZW), .IDX_W(IW)) bus ();
    fc_layer_seq_if #(.WIDTH(WIDTH), .ZW(ZW), .IDX_W(IW)) bus1 ();

    fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .ZW(ZW), .LAT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .x_out(x_out),
        .z_in(z_in), .busy(busy), .frame_done(frame_done)
    );

    fc_layer_seq #(.WIDTH(WIDTH), .IN(IN), .NEURONS(NEURONS), .ZW(ZW), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .bus(bus1), .x_out(x_out1),
        .z_in(z_in1), .busy(busy1), .frame_done(frame_done1)
    );

    // behavioural layer
    function automatic int wgt(input int n, input int k);
        if (n == 0) return 1;
        if (n == 1) return k + 1;
        return IN - k;
    endfunction

    function automatic logic [NEURONS*ZW-1:0] layer(input logic [IN*WIDTH-1:0] x);
        logic [NEURONS*ZW-1:0] z;
        z = '0;
        for (int n = 0; n < NEURONS; n++)
            for (int k = 0; k < IN; k++)
                z[slice_lo(n, ZW) +: ZW] += ZW'(wgt(n, k)) * ZW'(x[slice_lo(k, WIDTH) +: WIDTH]);
        return z;
    endfunction

    assign z_in = layer(x_out);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          iv;
        logic [7:0]    id;
        logic          ordy;
        logic          irdy;
        logic          ov;
        logic [IW-1:0] idx;
        logic [ZW-1:0] data;
        logic          last;
        logic          bsy;
        logic          fd;
    } vec_t;

    function automatic vec_t v(input logic iv, input int id, input logic ordy,
                               input logic irdy, input logic ov, input int idx,
                               input int data, input logic last, input logic bsy,
                               input logic fd);
        vec_t r;
        r.iv = iv; r.id = 8'(id); r.ordy = ordy; r.irdy = irdy; r.ov = ov;
        r.idx = IW'(idx); r.data = ZW'(data); r.last = last; r.bsy = bsy; r.fd = fd;
        return r;
    endfunction

    task automatic send_frame(input int a, input int b, input int c, input int d);
        int vals [4];
        vals = '{a, b, c, d};
        for (int k = 0; k < IN; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(vals[k]);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk(nm, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic drain_check(input string nm, input int e0, input int e1, input int e2);
        int exp [3];
        exp = '{e0, e1, e2};
        wait_valid({nm, "_valid"});
        for (int n = 0; n < NEURONS; n++) begin
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("%s_beat%0d", nm, n),
                {bus.out_idx, bus.out_data, bus.out_last},
                {IW'(n), ZW'(exp[n]), n == NEURONS - 1});
            tick();
        end
        bus.out_ready = 1'b0;
        chk({nm, "_frame_done"}, 64'(frame_done), 64'd1);
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; flush1 = 1'b0;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        z_in1 = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("reset_outputs",
            {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, busy, frame_done},
            {1'b1, 1'b0, IW'(0), ZW'(0), 1'b0, 1'b0, 1'b0});
        chk("reset_x_out", 64'(x_out), 64'd0);

        // basic frame 1,2,3,4 -> 10,30,20 with backpressure on idx 1;
        // then a bubbled frame 5,6,7,8 -> 26,70,60
        tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 3, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 4, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 10, 0, 1, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 0, 0, 0, 1, 1, 30, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 1, 30, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 2, 20, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 99, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 6, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 99, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 7, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 99, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 8, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 26, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 1, 70, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 2, 60, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            bus.in_valid  = tbl[i].iv;
            bus.in_data   = tbl[i].id;
            bus.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d", i),
                {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, busy, frame_done},
                {tbl[i].irdy, tbl[i].ov, tbl[i].idx, tbl[i].data, tbl[i].last, tbl[i].bsy, tbl[i].fd});
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        // flush during DRAIN at idx 1, coincident with out_ready
        send_frame(1, 2, 3, 4);
        wait_valid("flush_valid");
        bus.out_ready = 1'b1;
        #1;
        chk("flush_beat0", {bus.out_idx, bus.out_data}, {IW'(0), ZW'(10)});
        tick();
        chk("flush_at_idx1", {bus.out_idx, bus.out_data}, {IW'(1), ZW'(30)});
        flush = 1'b1;
        tick();
        flush = 1'b0; bus.out_ready = 1'b0;
        chk("flush_after",
            {bus.in_ready, bus.out_valid, bus.out_idx, busy, frame_done},
            {1'b1, 1'b0, IW'(0), 1'b0, 1'b0});
        tick();
        chk("flush_no_done", 64'(frame_done), 64'd0);
        send_frame(2, 2, 2, 2);
        drain_check("post_flush", 8, 20, 20);

        // rst asserted in SETTLE
        tick();
        send_frame(9, 9, 9, 9);
        chk("rst_in_settle_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs",
            {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, busy, frame_done},
            {1'b1, 1'b0, IW'(0), ZW'(0), 1'b0, 1'b0, 1'b0});
        chk("rst_mid_x_out", 64'(x_out), 64'd0);
        send_frame(1, 0, 0, 2);
        drain_check("post_rst", 3, 9, 6);

        // LAT=1: capture must see the z_in present one cycle after the last accept
        tick();
        z_in1 = {ZW'(3), ZW'(2), ZW'(1)};
        for (int k = 0; k < IN; k++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = 8'(k + 1);
            tick();
        end
        bus1.in_valid = 1'b0;
        z_in1 = {ZW'(30), ZW'(20), ZW'(10)};
        #1;
        chk("lat1_settle", {bus1.in_ready, bus1.out_valid, busy1}, {1'b0, 1'b0, 1'b1});
        tick();
        z_in1 = {ZW'(300), ZW'(200), ZW'(100)};
        chk("lat1_drain", 64'(bus1.out_valid), 64'd1);
        for (int n = 0; n < NEURONS; n++) begin
            bus1.out_ready = 1'b1;
            #1;
            chk($sformatf("lat1_beat%0d", n),
                {bus1.out_idx, bus1.out_data, bus1.out_last},
                {IW'(n), ZW'((n + 1) * 10), n == NEURONS - 1});
            tick();
        end
        bus1.out_ready = 1'b0;
        chk("lat1_frame_done", 64'(frame_done1), 64'd1);
        tick();
        chk("lat1_done_pulse", 64'(frame_done1), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
Frame sequencer for the combinational fully-connected layer datapath (constant-weight Booth multipliers feeding an adder tree and ReLU, one instance per output neuron).
- Accepts one input activation per handshake and assembles a full IN-element frame in a register buffer.
- Holds that buffer stable on the layer inputs for a programmed settle window, then snapshots all neuron outputs.
- Streams the neuron results out one per handshake, so the untimed combinational layer can be used inside a clocked pipeline.

Parameters:
WIDTH, 8, activation width in bits (matches layer WIDTH)
IN, 400, activations per frame (matches layer IN)
NEURONS, 10, number of layer instances fed in parallel
ZW, 2*WIDTH+$clog2(IN) = 25, width of each neuron result
LAT, 2, settle cycles between buffer-full and capture; legal range 1..255

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous abort of the current frame
in_valid  in  1  input activation valid
in_ready  out  1  sequencer accepts an activation
in_data  in  WIDTH  activation, unsigned
x_out  out  IN*WIDTH  flattened frame buffer to every layer instance; element k is at bits [k*WIDTH +: WIDTH]
z_in  in  NEURONS*ZW  flattened layer results; neuron n is at bits [n*ZW +: ZW]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  ZW  captured result of neuron out_idx
out_idx  out  $clog2(NEURONS)  neuron index of out_data
out_last  out  1  high with the result of neuron NEURONS-1
busy  out  1  sequencer is in SETTLE or DRAIN
frame_done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and overrides everything.
- Reset values:
  - state = LOAD; wr_cnt = rd_cnt = set_cnt = 0.
  - x_out = 0; captured results = 0.
  - in_ready = 1; out_valid = 0; out_last = 0; busy = 0; frame_done = 0; out_idx = 0; out_data = 0.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready: write buf[wr_cnt] = in_data and increment wr_cnt.
  - On the accept where wr_cnt == IN-1: go to SETTLE, clear wr_cnt, set set_cnt = 0.
- SETTLE:
  - in_ready = 0, busy = 1; x_out is held constant.
  - set_cnt increments each cycle.
  - On the cycle with set_cnt == LAT-1: register every z_in slice into cap[n], then go to DRAIN with rd_cnt = 0.
  - z_in is sampled exactly LAT cycles after the last accepted input. Timing constraints must give the layer a LAT-cycle multicycle path from x_out to the capture registers.
- DRAIN:
  - out_valid = 1, busy = 1.
  - out_data = cap[rd_cnt]; out_idx = rd_cnt; out_last = (rd_cnt == NEURONS-1).
  - out_data and out_idx stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: increment rd_cnt.
  - On the accept with out_last = 1: go to LOAD and pulse frame_done for the next cycle.
- Frame handoff: in_ready stays 0 for the whole of SETTLE and DRAIN. Frames never overlap, and the buffer is not overwritten until the drain completes.
- Data handling: x_out keeps the previous frame's values until overwritten element by element. Results are passed through unmodified; the ReLU is already applied inside the layer.
- flush:
  - In any state, flush returns the block to LOAD and clears all counters, out_valid and busy.
  - x_out and cap are not cleared.
  - frame_done is not pulsed.
  - flush takes priority over a coincident handshake: that input or output beat is discarded.
- rst mid-frame: identical to flush, plus the register clears listed above.
- Counter widths: wr_cnt $clog2(IN), rd_cnt $clog2(NEURONS), set_cnt 8 bits. Counters never wrap past their terminal values.

Decomposition:
- Package fc_seq_pkg holds:
  - state enum {LOAD, SETTLE, DRAIN};
  - localparams ZW_DEF, CNT_W(IN) and IDX_W(NEURONS);
  - the slice-index helper functions.
- One natural sub-module, fc_frame_buf: IN x WIDTH write-indexed register file with flattened read-all output.
- Capture registers, counters and the FSM live in fc_layer_seq.

Test Plan:
- Basic frame, IN=4, NEURONS=3, LAT=2: stream activations 1,2,3,4 back-to-back with z_in modelled as a combinational dot product.
  - -> in_ready drops on the cycle after the 4th accept.
  - -> capture occurs 2 cycles later.
  - -> out_idx 0,1,2 are presented with out_last only on idx 2.
  - -> frame_done pulses once.
- Output backpressure: out_ready low for 5 cycles on idx 1 -> out_data/out_idx stay stable; no beat is skipped or duplicated.
- Input bubbles: in_valid toggling 1,0,1,0 -> only accepted beats are written; SETTLE is entered only after exactly IN accepts.
- LAT=1 boundary: z_in changes after capture -> captured value reflects z_in one cycle after the last accept.
- flush during DRAIN at idx 1, coincident with out_ready -> next cycle state=LOAD, out_valid=0, no frame_done; the next frame runs normally.
- rst asserted in SETTLE -> all outputs at reset values next cycle; a full frame afterwards produces correct results.
